rob_multi_commit: RTL and testbench
===================================

// Module: rob_multi_commit
// PURPOSE
// Parametrised reorder buffer for the OoO core. Sits between dispatch, the CDB and the regfile commit port.
// Allocates entries in program order and captures results from CDB_PORTS writeback channels.
// Retires up to COMMIT_W done entries per cycle, in order.
// A mispredicted branch at commit raises a self-generated flush and a redirect PC.
// PARAMETERS
// DEPTH     32  entries; power of two, >=4; IDX_W = $clog2(DEPTH)
// CDB_PORTS 4   number of independent writeback channels
// COMMIT_W  2   max entries retired per cycle (1..4)
// XLEN      32  data/PC width
// PORTS
// clk            in   1                clock
// rst            in   1                reset
// enq_valid      in   1                dispatch offers an instruction
// enq_ready      out  1                entry available (count < DEPTH)
// enq_pc         in   XLEN             instruction PC
// enq_rd         in   5                destination arch reg
// enq_we         in   1                writes regfile
// enq_is_br      in   1                control-flow instruction
// enq_idx        out  IDX_W            index given to the offered instruction (= tail)
// wb_valid       in   CDB_PORTS        per-channel writeback strobe
// wb_idx         in   CDB_PORTS*IDX_W  target ROB index per channel
// wb_data        in   CDB_PORTS*XLEN   result per channel
// wb_mispred     in   CDB_PORTS        branch resolved mispredicted
// wb_target      in   CDB_PORTS*XLEN   correct next PC per channel
// rd_idx         in   2*IDX_W          two operand lookup indices
// rd_ready       out  2                looked-up entry has a result
// rd_data        out  2*XLEN           looked-up result
// commit_valid   out  COMMIT_W         retire slot k valid this cycle
// commit_rd      out  COMMIT_W*5       retire slot arch reg
// commit_we      out  COMMIT_W         retire slot writes regfile
// commit_data    out  COMMIT_W*XLEN    retire slot value
// flush          out  1                pipeline flush pulse
// redirect_pc    out  XLEN             fetch redirect target, valid with flush
// count          out  IDX_W+1          occupied entries
// BEHAVIOUR
// - Reset (rst, sync): head = tail = 0; count = 0; all entry valid/done bits = 0.
//   All commit_valid = 0, flush = 0, redirect_pc = 0, rd_ready = 0.
// - Pointers are IDX_W+1 bits. The MSB is the wrap bit. Full = count == DEPTH; empty = count == 0.
// - Enqueue: on enq_valid && enq_ready, write entry[tail]: valid = 1, done = 0, mispred = 0; tail++.
//   enq_idx is combinational from tail. enq_ready is based on registered count only.
//   Slots freed by commit in the same cycle do not raise enq_ready until the next cycle.
// - Writeback: for each channel c with wb_valid[c], if entry[wb_idx[c]].valid, then in the next cycle:
//   done = 1, data = wb_data[c], mispred = wb_mispred[c], target = wb_target[c].
//   A writeback to an invalid entry is ignored.
//   If two channels hit the same index, the highest-numbered channel wins.
// - Operand lookup: rd_ready/rd_data are combinational from the entry, with CDB bypass.
//   A same-cycle wb hitting rd_idx returns ready = 1 and the wb data (highest channel wins).
// - Commit (combinational from registered state, registered into outputs next edge):
//   Slot k retires entry head+k iff slots 0..k-1 retire, entry is valid && done, and k < count.
//   A slot whose entry has mispred = 1 retires, but no younger slot retires in that cycle.
//   Retired entries: valid = 0; head += retired; count -= retired.
//   Outputs are registered: commit_* are 1-cycle pulses, one cycle after the retire decision.
//   Minimum writeback-to-commit_valid latency = 2 cycles.
// - Flush: a retired mispredicted entry sets flush = 1 and redirect_pc = target.
//   Both are registered and asserted in the same cycle as that entry's commit_valid.
//   On that edge: head = tail = count = 0, all valid = 0.
//   A same-cycle enqueue is dropped; same-cycle writebacks are dropped.
//   flush is a 1-cycle pulse; enq_ready = 1 the next cycle.
// - Simultaneous enqueue + commit: count += enq - retired; no conflict (different entries).
// - Wrap: index arithmetic is modulo DEPTH. count never exceeds DEPTH or underflows.
// - rst overrides everything, including a pending flush or commit.
// TESTING
// - Reset, then fill DEPTH enqueues with no wb -> enq_ready = 0 at count = 32; enq_idx 0..31 handed out.
// - Out-of-order wb to idx 2, 1, 0 on channels 3, 1, 0 -> slots 0 and 1 commit idx 0,1 in one cycle; idx 2 next cycle.
// - Wrap: cycle 40 instructions through DEPTH = 32 -> commit order and rd/data exact; count returns to 0.
// - Mispredict at idx 5 (target 0x8000_0100) with idx 6 done -> idx 5 commits alone, flush = 1, redirect_pc = 0x8000_0100.
//   Same-cycle enq dropped; count = 0.
// - Same-cycle wb conflict, ch0 = 0xA, ch3 = 0xB to idx 4 -> committed data 0xB; rd lookup of idx 4 in that cycle returns 0xB.
// - rst asserted during back-to-back commit -> next cycle all outputs at reset values, enq_idx = 0.

Source files
------------

// File: rtl/rob_multi_commit.sv
// rob_multi_commit: reorder buffer with in-order multi-slot retirement.
// Dispatch allocates entries at the tail in program order. CDB_PORTS writeback
// channels mark entries done. Up to COMMIT_W done entries retire per cycle from
// the head. A retiring mispredicted branch raises a one-cycle flush with a
// redirect PC and empties the buffer.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   enq_valid/ready/pc/rd/we/is_br dispatch handshake and payload
//   enq_idx                        ROB index given to the offered instruction
//   wb_valid/idx/data/mispred/target per-channel writeback bus
//   rd_idx -> rd_ready/rd_data     two operand lookups with CDB bypass
//   commit_valid/rd/we/data        registered retire slots (1-cycle pulses)
//   flush, redirect_pc             registered mispredict flush and target
//   count                          occupied entries
module rob_multi_commit #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned CDB_PORTS = 4,
  parameter int unsigned COMMIT_W  = 2,
  parameter int unsigned XLEN      = 32,
  localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enq_valid,
  output logic                      enq_ready,
  input  logic [XLEN-1:0]           enq_pc,
  input  logic [4:0]                enq_rd,
  input  logic                      enq_we,
  input  logic                      enq_is_br,
  output logic [IDX_W-1:0]          enq_idx,
  input  logic [CDB_PORTS-1:0]      wb_valid,
  input  logic [CDB_PORTS*IDX_W-1:0] wb_idx,
  input  logic [CDB_PORTS*XLEN-1:0] wb_data,
  input  logic [CDB_PORTS-1:0]      wb_mispred,
  input  logic [CDB_PORTS*XLEN-1:0] wb_target,
  input  logic [2*IDX_W-1:0]        rd_idx,
  output logic [1:0]                rd_ready,
  output logic [2*XLEN-1:0]         rd_data,
  output logic [COMMIT_W-1:0]       commit_valid,
  output logic [COMMIT_W*5-1:0]     commit_rd,
  output logic [COMMIT_W-1:0]       commit_we,
  output logic [COMMIT_W*XLEN-1:0]  commit_data,
  output logic                      flush,
  output logic [XLEN-1:0]           redirect_pc,
  output logic [IDX_W:0]            count
);

  localparam int unsigned PTR_W = IDX_W + 1;

  // Entry storage
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_done;
  logic [DEPTH-1:0] ent_mispred;
  logic [DEPTH-1:0] ent_we;
  logic [4:0]       ent_rd     [DEPTH];
  logic [XLEN-1:0]  ent_data   [DEPTH];
  logic [XLEN-1:0]  ent_target [DEPTH];

  // Pointers carry a wrap bit above the index
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] count_q;

  logic             enq_fire;
  logic [IDX_W-1:0] tail_idx;

  // Retire decision
  logic [IDX_W-1:0]    cidx [COMMIT_W];
  logic [COMMIT_W-1:0] ret;
  logic [PTR_W-1:0]    n_ret;
  logic                blocked;
  logic                flush_d;
  logic [XLEN-1:0]     target_d;

  // Operand lookup
  logic [IDX_W-1:0] rsel [2];

  // PC and branch flag are carried by dispatch but not needed for retirement
  logic unused_inputs;
  assign unused_inputs = ^{enq_pc, enq_is_br};

  // Full is judged on registered count only; same-cycle retires do not help
  assign enq_ready = (count_q < PTR_W'(DEPTH));
  assign enq_fire  = enq_valid & enq_ready;
  assign tail_idx  = tail[IDX_W-1:0];
  assign enq_idx   = tail_idx;
  assign count     = count_q;

  // In-order retire: a slot needs all older slots retiring; a mispredict stops younger slots
  always_comb begin
    ret      = '0;
    n_ret    = '0;
    blocked  = 1'b0;
    flush_d  = 1'b0;
    target_d = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      cidx[k] = head[IDX_W-1:0] + IDX_W'(k);
      if (!blocked && (PTR_W'(k) < count_q) && ent_valid[cidx[k]] && ent_done[cidx[k]]) begin
        ret[k] = 1'b1;
        n_ret  = n_ret + PTR_W'(1);
        if (ent_mispred[cidx[k]]) begin
          blocked  = 1'b1;
          flush_d  = 1'b1;
          target_d = ent_target[cidx[k]];
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

  // Operand lookup with CDB bypass; highest channel wins
  always_comb begin
    rd_ready = '0;
    rd_data  = '0;
    for (int j = 0; j < 2; j++) begin
      rsel[j] = rd_idx[j*IDX_W +: IDX_W];
      rd_ready[j] = ent_valid[rsel[j]] & ent_done[rsel[j]];
      rd_data[j*XLEN +: XLEN] = ent_data[rsel[j]];
      for (int c = 0; c < CDB_PORTS; c++) begin
        if (wb_valid[c] && ent_valid[rsel[j]] && (wb_idx[c*IDX_W +: IDX_W] == rsel[j])) begin
          rd_ready[j] = 1'b1;
          rd_data[j*XLEN +: XLEN] = wb_data[c*XLEN +: XLEN];
        end
      end
    end
  end

  // Buffer state: writeback, allocate, retire; flush discards everything
  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count_q     <= '0;
      ent_valid   <= '0;
      ent_done    <= '0;
      ent_mispred <= '0;
    end else if (flush_d) begin
      head        <= '0;
      tail        <= '0;
      count_q     <= '0;
      ent_valid   <= '0;
      ent_done    <= '0;
      ent_mispred <= '0;
    end else begin
      // Later channels overwrite earlier ones on an index collision
      for (int i = 0; i < DEPTH; i++) begin
        for (int c = 0; c < CDB_PORTS; c++) begin
          if (wb_valid[c] && ent_valid[i] && (wb_idx[c*IDX_W +: IDX_W] == IDX_W'(i))) begin
            ent_done[i]    <= 1'b1;
            ent_data[i]    <= wb_data[c*XLEN +: XLEN];
            ent_mispred[i] <= wb_mispred[c];
            ent_target[i]  <= wb_target[c*XLEN +: XLEN];
          end
        end
      end
      if (enq_fire) begin
        ent_valid[tail_idx]   <= 1'b1;
        ent_done[tail_idx]    <= 1'b0;
        ent_mispred[tail_idx] <= 1'b0;
        ent_rd[tail_idx]      <= enq_rd;
        ent_we[tail_idx]      <= enq_we;
        tail                  <= tail + PTR_W'(1);
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        if (ret[k]) ent_valid[cidx[k]] <= 1'b0;
      end
      head    <= head + n_ret;
      count_q <= count_q + PTR_W'(enq_fire) - n_ret;
    end
  end

  // Registered retire outputs and flush
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_valid <= '0;
      commit_rd    <= '0;
      commit_we    <= '0;
      commit_data  <= '0;
      flush        <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      commit_valid <= ret;
      flush        <= flush_d;
      if (flush_d) redirect_pc <= target_d;
      for (int k = 0; k < COMMIT_W; k++) begin
        commit_rd[k*5 +: 5]         <= ent_rd[cidx[k]];
        commit_we[k]                <= ret[k] & ent_we[cidx[k]];
        commit_data[k*XLEN +: XLEN] <= ent_data[cidx[k]];
      end
    end
  end

endmodule

// File: tb/tb_rob_multi_commit.sv
// tb_rob_multi_commit: directed self-checking bench for rob_multi_commit
// (DEPTH 32, 4 CDB channels, 2 commit slots, XLEN 32).
module tb_rob_multi_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic [4:0]  enq_rd;
  logic        enq_we;
  logic        enq_is_br;
  logic [4:0]  enq_idx;
  logic [3:0]  wb_valid;
  logic [19:0] wb_idx;
  logic [127:0] wb_data;
  logic [3:0]  wb_mispred;
  logic [127:0] wb_target;
  logic [9:0]  rd_idx;
  logic [1:0]  rd_ready;
  logic [63:0] rd_data;
  logic [1:0]  commit_valid;
  logic [9:0]  commit_rd;
  logic [1:0]  commit_we;
  logic [63:0] commit_data;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [5:0]  count;

  int checks   = 0;
  int failures = 0;
  int ncommit  = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t expq[$];

  always #5 clk = ~clk;

  rob_multi_commit #(.DEPTH(32), .CDB_PORTS(4), .COMMIT_W(2), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc), .enq_rd(enq_rd),
    .enq_we(enq_we), .enq_is_br(enq_is_br), .enq_idx(enq_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .wb_mispred(wb_mispred), .wb_target(wb_target),
    .rd_idx(rd_idx), .rd_ready(rd_ready), .rd_data(rd_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_we(commit_we),
    .commit_data(commit_data), .flush(flush), .redirect_pc(redirect_pc), .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_wb();
    wb_valid   = '0;
    wb_mispred = '0;
  endtask

  task automatic wb_set(input int c, input int idx, input logic [31:0] d,
                        input logic m, input logic [31:0] t);
    wb_valid[c]           = 1'b1;
    wb_idx[c*5 +: 5]      = 5'(idx);
    wb_data[c*32 +: 32]   = d;
    wb_mispred[c]         = m;
    wb_target[c*32 +: 32] = t;
  endtask

  task automatic push_exp(input int rd, input logic [31:0] d);
    exp_t e;
    e.rd   = 5'(rd);
    e.data = d;
    expq.push_back(e);
  endtask

  // Advance one cycle and score any retire slots against the expected queue
  task automatic tick_chk();
    exp_t e;
    tick();
    chk("commit_order", 64'(commit_valid[1] & ~commit_valid[0]), 64'(0));
    for (int k = 0; k < 2; k++) begin
      if (commit_valid[k]) begin
        if (expq.size() == 0) begin
          chk("commit_extra", 64'(commit_valid[k]), 64'(0));
        end else begin
          e = expq.pop_front();
          chk("commit_rd", 64'(commit_rd[k*5 +: 5]), 64'(e.rd));
          chk("commit_data", 64'(commit_data[k*32 +: 32]), 64'(e.data));
          chk("commit_we", 64'(commit_we[k]), 64'(1));
          ncommit++;
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enq_valid = 1'b0; enq_pc = '0; enq_rd = '0; enq_we = 1'b0; enq_is_br = 1'b0;
    wb_valid = '0; wb_idx = '0; wb_data = '0; wb_mispred = '0; wb_target = '0; rd_idx = '0;
    tick();
    tick();
    // Reset state
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_enq_ready", 64'(enq_ready), 64'(1));
    chk("rst_enq_idx", 64'(enq_idx), 64'(0));
    chk("rst_commit_valid", 64'(commit_valid), 64'(0));
    chk("rst_flush", 64'(flush), 64'(0));
    chk("rst_redirect", 64'(redirect_pc), 64'(0));
    chk("rst_rd_ready", 64'(rd_ready), 64'(0));
    rst = 1'b0;

    // Fill all 32 entries with no writeback
    for (int i = 0; i < 32; i++) begin
      enq_valid = 1'b1; enq_rd = 5'(i); enq_we = 1'b1; enq_pc = 32'h1000 + 32'(4 * i);
      settle();
      chk("fill_enq_idx", 64'(enq_idx), 64'(i));
      chk("fill_enq_ready", 64'(enq_ready), 64'(1));
      tick();
    end
    chk("full_count", 64'(count), 64'(32));
    chk("full_enq_ready", 64'(enq_ready), 64'(0));
    tick();
    chk("full_drop_count", 64'(count), 64'(32));
    chk("full_tail_wrap", 64'(enq_idx), 64'(0));
    enq_valid = 1'b0;

    // Out-of-order writeback: idx2 (ch3), idx1 (ch1), idx0 (ch0)
    clear_wb(); wb_set(3, 2, 32'h102, 1'b0, 32'h0);
    tick();
    clear_wb(); wb_set(1, 1, 32'h101, 1'b0, 32'h0);
    tick();
    clear_wb(); wb_set(0, 0, 32'h100, 1'b0, 32'h0);
    rd_idx = {5'd1, 5'd0};
    settle();
    chk("ooo_rd_ready", 64'(rd_ready), 64'(2'b11));
    chk("ooo_rd_data0", 64'(rd_data[31:0]), 64'(32'h100));
    chk("ooo_rd_data1", 64'(rd_data[63:32]), 64'(32'h101));
    tick();
    clear_wb();
    chk("ooo_cv_wait", 64'(commit_valid), 64'(0));
    chk("ooo_count_hold", 64'(count), 64'(32));
    chk("ooo_ready_hold", 64'(enq_ready), 64'(0));
    tick();
    chk("ooo_cv_pair", 64'(commit_valid), 64'(2'b11));
    chk("ooo_rd_pair", 64'(commit_rd), 64'({5'd1, 5'd0}));
    chk("ooo_data_pair", 64'(commit_data), {32'h101, 32'h100});
    chk("ooo_count30", 64'(count), 64'(30));
    chk("ooo_ready_back", 64'(enq_ready), 64'(1));
    tick();
    chk("ooo_cv_single", 64'(commit_valid), 64'(2'b01));
    chk("ooo_rd2", 64'(commit_rd[4:0]), 64'(2));
    chk("ooo_data2", 64'(commit_data[31:0]), 64'(32'h102));
    chk("ooo_count29", 64'(count), 64'(29));
    tick();
    chk("ooo_cv_idle", 64'(commit_valid), 64'(0));

    // Drain remaining idx 3..31
    ncommit = 0;
    for (int i = 3; i < 32; i++) begin
      clear_wb(); wb_set(0, i, 32'h200 + 32'(i), 1'b0, 32'h0);
      push_exp(i, 32'h200 + 32'(i));
      tick_chk();
    end
    clear_wb();
    for (int n = 0; n < 8 && count != 0; n++) tick_chk();
    chk("drain_count", 64'(count), 64'(0));
    chk("drain_ncommit", 64'(ncommit), 64'(29));
    chk("drain_q", 64'(expq.size()), 64'(0));

    // Stream 40 instructions through the ring
    ncommit = 0;
    for (int t = 0; t <= 40; t++) begin
      clear_wb(); enq_valid = 1'b0;
      if (t < 40) begin
        enq_valid = 1'b1; enq_rd = 5'(t); enq_we = 1'b1;
      end
      if (t >= 1) begin
        wb_set(t % 4, t - 1, 32'h1000 + 32'(t - 1), 1'b0, 32'h0);
        rd_idx[9:5] = 5'(t - 1);
        push_exp(t - 1, 32'h1000 + 32'(t - 1));
      end
      settle();
      if (t < 40) begin
        chk("wrap_enq_idx", 64'(enq_idx), 64'(t % 32));
        chk("wrap_enq_ready", 64'(enq_ready), 64'(1));
      end
      if (t >= 1) begin
        chk("wrap_byp_ready", 64'(rd_ready[1]), 64'(1));
        chk("wrap_byp_data", 64'(rd_data[63:32]), 64'(32'h1000 + 32'(t - 1)));
      end
      tick_chk();
    end
    clear_wb(); enq_valid = 1'b0;
    for (int n = 0; n < 8 && count != 0; n++) tick_chk();
    chk("wrap_count", 64'(count), 64'(0));
    chk("wrap_ncommit", 64'(ncommit), 64'(40));
    chk("wrap_q", 64'(expq.size()), 64'(0));

    // Mispredict at idx5 with idx6 already done
    rst = 1'b1; tick(); rst = 1'b0;
    expq.delete();
    chk("mp_rst_count", 64'(count), 64'(0));
    for (int i = 0; i < 7; i++) begin
      enq_valid = 1'b1; enq_rd = 5'(10 + i); enq_we = 1'b1; enq_is_br = (i == 5);
      tick();
    end
    enq_valid = 1'b0; enq_is_br = 1'b0;
    clear_wb();
    for (int c = 0; c < 4; c++) begin
      wb_set(c, c, 32'h300 + 32'(c), 1'b0, 32'h0);
      push_exp(10 + c, 32'h300 + 32'(c));
    end
    tick_chk();
    clear_wb();
    wb_set(0, 4, 32'h304, 1'b0, 32'h0);
    wb_set(2, 6, 32'h306, 1'b0, 32'h0);
    push_exp(14, 32'h304);
    tick_chk();
    clear_wb();
    tick_chk();
    chk("mp_cv_23", 64'(commit_valid), 64'(2'b11));
    clear_wb();
    wb_set(1, 5, 32'h305, 1'b1, 32'h8000_0100);
    push_exp(15, 32'h305);
    tick_chk();
    chk("mp_cv_4", 64'(commit_valid), 64'(2'b01));
    chk("mp_noflush_yet", 64'(flush), 64'(0));
    clear_wb();
    enq_valid = 1'b1; enq_rd = 5'd31;
    wb_set(2, 6, 32'h999, 1'b0, 32'h0);
    tick_chk();
    chk("mp_cv_alone", 64'(commit_valid), 64'(2'b01));
    chk("mp_flush", 64'(flush), 64'(1));
    chk("mp_redirect", 64'(redirect_pc), 64'(32'h8000_0100));
    chk("mp_count", 64'(count), 64'(0));
    chk("mp_enq_ready", 64'(enq_ready), 64'(1));
    chk("mp_enq_idx", 64'(enq_idx), 64'(0));
    chk("mp_q", 64'(expq.size()), 64'(0));
    clear_wb(); enq_valid = 1'b0;
    rd_idx = {5'd6, 5'd6};
    settle();
    chk("mp_rd_gone", 64'(rd_ready), 64'(0));
    tick_chk();
    chk("mp_flush_pulse", 64'(flush), 64'(0));
    chk("mp_cv_idle", 64'(commit_valid), 64'(0));
    chk("mp_count_idle", 64'(count), 64'(0));

    // Same-cycle writeback conflict on idx4: ch3 beats ch0
    for (int i = 0; i < 5; i++) begin
      enq_valid = 1'b1; enq_rd = 5'(20 + i); enq_we = 1'b1;
      tick();
    end
    enq_valid = 1'b0;
    clear_wb();
    for (int c = 0; c < 4; c++) begin
      wb_set(c, c, 32'h400 + 32'(c), 1'b0, 32'h0);
      push_exp(20 + c, 32'h400 + 32'(c));
    end
    rd_idx = {5'd0, 5'd4};
    settle();
    chk("cf_rd_notready", 64'(rd_ready[0]), 64'(0));
    tick_chk();
    clear_wb();
    wb_set(0, 4, 32'hA, 1'b0, 32'h0);
    wb_set(3, 4, 32'hB, 1'b0, 32'h0);
    push_exp(24, 32'hB);
    settle();
    chk("cf_rd_ready", 64'(rd_ready[0]), 64'(1));
    chk("cf_rd_data", 64'(rd_data[31:0]), 64'(32'hB));
    tick_chk();
    clear_wb();
    for (int n = 0; n < 8 && count != 0; n++) tick_chk();
    chk("cf_count", 64'(count), 64'(0));
    chk("cf_q", 64'(expq.size()), 64'(0));

    // Reset in the middle of back-to-back commits (entries idx5..10)
    for (int i = 0; i < 6; i++) begin
      enq_valid = 1'b1; enq_rd = 5'(25 + i); enq_we = 1'b1;
      tick();
    end
    enq_valid = 1'b0;
    clear_wb();
    for (int c = 0; c < 4; c++) wb_set(c, 5 + c, 32'h500 + 32'(c), 1'b0, 32'h0);
    push_exp(25, 32'h500);
    push_exp(26, 32'h501);
    tick_chk();
    clear_wb();
    wb_set(0, 9, 32'h504, 1'b0, 32'h0);
    wb_set(1, 10, 32'h505, 1'b0, 32'h0);
    tick_chk();
    chk("rr_cv_pair", 64'(commit_valid), 64'(2'b11));
    clear_wb();
    rd_idx = {5'd9, 5'd9};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("rr_cv", 64'(commit_valid), 64'(0));
    chk("rr_we", 64'(commit_we), 64'(0));
    chk("rr_flush", 64'(flush), 64'(0));
    chk("rr_redirect", 64'(redirect_pc), 64'(0));
    chk("rr_count", 64'(count), 64'(0));
    chk("rr_enq_idx", 64'(enq_idx), 64'(0));
    chk("rr_enq_ready", 64'(enq_ready), 64'(1));
    chk("rr_rd_ready", 64'(rd_ready), 64'(0));
    chk("rr_q", 64'(expq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
